// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer:
// default widths, reset PC, the fetch-entry bundle and the drain FSM states.
package if_prefetch_buffer_pkg;

    localparam int          PF_XLEN     = 32;
    localparam logic [31:0] PF_RESET_PC = 32'h0;

    typedef struct packed {
        logic [PF_XLEN-1:0] pc;
        logic [PF_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        PF_RUN   = 1'b0,
        PF_DRAIN = 1'b1
    } pf_state_e;

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Bus bundle of the prefetch buffer: imem request/response and IF-side fetch handshake.
// master = prefetch buffer, slave = memory + IF stage environment.
interface if_prefetch_buffer_if
    import if_prefetch_buffer_pkg::*;
#(
    parameter int XLEN = PF_XLEN
);

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output fetch_valid, fetch_instr, fetch_pc,
        input  fetch_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  fetch_valid, fetch_instr, fetch_pc,
        output fetch_ready
    );

endinterface

// File: rtl/if_prefetch_buffer_pf_fifo.sv
// pf_fifo: DEPTH-entry circular buffer with push/pop/flush and occupancy count.
// Ports: flush_i (priority, empties), push_i/push_data_i, pop_i, head_o, count_o.
module pf_fifo
    import if_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * PF_XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_i}
                              - {{AW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: sequential instruction prefetch queue feeding the IF/ID register.
// Ports: clk, rst_n (sync, active-low), pf_bus (imem req/rsp + fetch handshake),
//        redirect_valid/redirect_pc (flush + restart). Define IF_PREFETCH_PERF_EN to add
//        perf_flush_cnt / perf_empty_cnt saturating event counters.
module if_prefetch_buffer
    import if_prefetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = PF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PF_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_prefetch_buffer_if.master pf_bus,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_empty_cnt
`endif
);

    // Inflight can exceed DEPTH while stale streams drain; give headroom.
    localparam int CW = $clog2(DEPTH) + 4;

    logic [XLEN-1:0]         next_pc_q, next_pc_d;
    logic [XLEN-1:0]         rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           discard_q, discard_d;
    pf_state_e               state_q, state_d;
    logic [$clog2(DEPTH):0]  cnt;
    logic [2*XLEN-1:0]       head;
    logic [CW-1:0]           used;
    logic                    req_valid, issue;
    logic                    rsp_acc, drop, keep;
    logic                    fetch_valid, pop;

    // Space is reserved at issue, so the queue can never overflow.
    assign used      = (inflight_q - discard_q) + CW'(cnt);
    assign req_valid = !redirect_valid && (used < CW'(DEPTH));
    assign issue     = req_valid && pf_bus.imem_req_ready;

    // A response with nothing outstanding is a bus error and is ignored.
    assign rsp_acc = pf_bus.imem_rsp_valid && (inflight_q != '0);
    assign drop    = rsp_acc && (state_q == PF_DRAIN);
    assign keep    = rsp_acc && !drop && !redirect_valid;

    assign fetch_valid = (cnt != '0);
    assign pop         = fetch_valid && pf_bus.fetch_ready && !redirect_valid;

    always_comb begin
        next_pc_d  = next_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (rsp_acc) inflight_d = inflight_q - 1'b1;
        if (redirect_valid) begin
            next_pc_d = redirect_pc;
            rsp_pc_d  = redirect_pc;
            // Everything still outstanding now belongs to the dead stream.
            discard_d = inflight_d;
        end else begin
            if (issue) begin
                next_pc_d  = next_pc_q + XLEN'(4);
                inflight_d = inflight_d + 1'b1;
            end
            if (drop) discard_d = discard_q - 1'b1;
            // Fetch is strictly sequential, so a live response's PC is
            // the stream base plus four per response already accepted.
            if (keep) rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
        state_d = (discard_d != '0) ? PF_DRAIN : PF_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_pc_q  <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            state_q    <= PF_RUN;
        end else begin
            next_pc_q  <= next_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            state_q    <= state_d;
        end
    end

    pf_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (keep),
        .push_data_i ({rsp_pc_q, pf_bus.imem_rsp_data}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (cnt)
    );

    assign pf_bus.imem_req_valid = req_valid;
    assign pf_bus.imem_req_addr  = next_pc_q;
    assign pf_bus.fetch_valid    = fetch_valid;
    assign pf_bus.fetch_pc       = head[2*XLEN-1:XLEN];
    assign pf_bus.fetch_instr    = head[XLEN-1:0];

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] flush_cnt_q, empty_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            if (redirect_valid && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (!fetch_valid && pf_bus.fetch_ready && (empty_cnt_q != '1))
                empty_cnt_q <= empty_cnt_q + 32'd1;
        end
    end

    assign perf_flush_cnt = flush_cnt_q;
    assign perf_empty_cnt = empty_cnt_q;
`endif

endmodule
